// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I decode stage and the ALU it feeds:
// opcode values, ALU func codes, operand-select encodings and the
// decoded bundle that travels from decode to execute.
package alu_pkg;

  localparam int XLEN   = 32;
  localparam int FUNC_W = 4;

  // Major opcodes handled by this stage (inst[6:0], low bits included).
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  // ALU func codes; these must match the execute-stage ALU.
  localparam logic [FUNC_W-1:0] FUNC_ADD  = 4'b0000;
  localparam logic [FUNC_W-1:0] FUNC_XOR  = 4'b0001;
  localparam logic [FUNC_W-1:0] FUNC_OR   = 4'b0010;
  localparam logic [FUNC_W-1:0] FUNC_AND  = 4'b0011;
  localparam logic [FUNC_W-1:0] FUNC_SLLI = 4'b0100;
  localparam logic [FUNC_W-1:0] FUNC_SLL  = 4'b0101;
  localparam logic [FUNC_W-1:0] FUNC_SRL  = 4'b0110;
  localparam logic [FUNC_W-1:0] FUNC_SRLI = 4'b0111;
  localparam logic [FUNC_W-1:0] FUNC_SLT  = 4'b1000;
  localparam logic [FUNC_W-1:0] FUNC_SLTU = 4'b1001;

  // Operand A source select.
  localparam logic [1:0] A_SEL_RS1  = 2'b00;
  localparam logic [1:0] A_SEL_PC   = 2'b01;
  localparam logic [1:0] A_SEL_ZERO = 2'b10;

  // Operand B source select.
  localparam logic B_SEL_RS2 = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;

  // Everything execute needs for one instruction.
  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic              sub_sra;
    logic [4:0]        shamt;
    logic [1:0]        a_sel;
    logic              b_sel;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              rd_we;
    logic [XLEN-1:0]   pc;
    logic              illegal;
  } dec_bundle_t;

  // funct3 -> ALU func; the register and immediate forms differ only
  // for the two shift groups.
  function automatic logic [FUNC_W-1:0] alu_func(input logic [2:0] funct3,
                                                 input logic       is_imm);
    logic [FUNC_W-1:0] f;
    f = FUNC_ADD;
    case (funct3)
      3'b000:  f = FUNC_ADD;
      3'b001:  f = is_imm ? FUNC_SLLI : FUNC_SLL;
      3'b010:  f = FUNC_SLT;
      3'b011:  f = FUNC_SLTU;
      3'b100:  f = FUNC_XOR;
      3'b101:  f = is_imm ? FUNC_SRLI : FUNC_SRL;
      3'b110:  f = FUNC_OR;
      default: f = FUNC_AND;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu_inst_decode.sv
// Pure combinational decode of one RV32I instruction (OP, OP-IMM, LUI,
// AUIPC) into an ALU control bundle. Anything else comes out as an
// illegal bundle with all controls and register fields cleared.
module alu_inst_decode
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] pc,
  output dec_bundle_t     dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_shift_grp;
  logic       legal;
  dec_bundle_t raw;

  assign opcode       = inst[6:0];
  assign funct3       = inst[14:12];
  assign funct7       = inst[31:25];
  // funct3 001/101 are the shift groups, the only ones that use funct7/shamt.
  assign is_shift_grp = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Field extraction and legality check per opcode class.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    raw   = '0;
    legal = 1'b0;
    raw.pc = pc;
    case (opcode)
      OPC_OP: begin
        raw.func  = alu_func(funct3, 1'b0);
        raw.a_sel = A_SEL_RS1;
        raw.b_sel = B_SEL_RS2;
        raw.rs1   = inst[19:15];
        raw.rs2   = inst[24:20];
        raw.rd    = inst[11:7];
        raw.rd_we = 1'b1;
        // Only add/sub and srl/sra have an alternate (funct7=0100000) form.
        if (funct3 == 3'b000 || funct3 == 3'b101) begin
          raw.sub_sra = (funct7 == 7'b0100000);
          legal       = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        end else begin
          legal = (funct7 == 7'b0000000);
        end
      end
      OPC_OPIMM: begin
        raw.func  = alu_func(funct3, 1'b1);
        raw.a_sel = A_SEL_RS1;
        raw.b_sel = B_SEL_IMM;
        raw.imm   = {{20{inst[31]}}, inst[31:20]};
        raw.rs1   = inst[19:15];
        raw.rd    = inst[11:7];
        raw.rd_we = 1'b1;
        if (is_shift_grp) raw.shamt = inst[24:20];
        if (funct3 == 3'b001) begin
          legal = (funct7 == 7'b0000000);
        end else if (funct3 == 3'b101) begin
          raw.sub_sra = inst[30];
          legal       = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        end else begin
          legal = 1'b1;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        raw.func  = FUNC_ADD;
        raw.a_sel = (opcode == OPC_LUI) ? A_SEL_ZERO : A_SEL_PC;
        raw.b_sel = B_SEL_IMM;
        raw.imm   = {inst[31:12], 12'b0};
        raw.rd    = inst[11:7];
        raw.rd_we = 1'b1;
        legal     = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal instructions keep only the pc so the trap path can report it.
  always_comb begin
    dec = raw;
    if (!legal) begin
      dec         = '0;
      dec.pc      = pc;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode stage between fetch and execute. One output register
// plus a one-entry skid buffer give full throughput with a registered
// in_ready, and never drop an instruction under backpressure.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int FUNC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_inst,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FUNC_W-1:0] out_func,
  output logic              out_sub_sra,
  output logic [4:0]        out_shamt,
  output logic [1:0]        out_a_sel,
  output logic              out_b_sel,
  output logic [XLEN-1:0]   out_imm,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic              out_rd_we,
  output logic [XLEN-1:0]   out_pc,
  output logic              out_illegal
);

  dec_bundle_t dec;
  dec_bundle_t out_q;
  dec_bundle_t skid_q;
  logic        out_valid_q;
  logic        skid_valid_q;
  logic        accept;
  logic        load_out;

  alu_inst_decode u_decode (
    .inst (in_inst),
    .pc   (in_pc),
    .dec  (dec)
  );

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && !skid_valid_q;
  // The output register can take a new bundle when empty or draining.
  assign load_out = !out_valid_q || out_ready;

  // Occupancy of the output register and skid entry; flush empties both.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (load_out) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q  <= accept;
      end
    end else if (accept) begin
      skid_valid_q <= 1'b1;
    end
  end

  // Output payload: skid entry has priority over new input to keep order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else if (!flush && load_out) begin
      if (skid_valid_q) begin
        out_q <= skid_q;
      end else if (accept) begin
        out_q <= dec;
      end
    end
  end

  // Skid payload captures an input that arrives while the output stalls.
  always_ff @(posedge clk) begin
    // NOTE: no reset on this payload; it is only ever read when
    // skid_valid_q is set, and skid_valid_q is reset.
    if (!flush && !load_out && accept) begin
      skid_q <= dec;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_func    = out_q.func;
  assign out_sub_sra = out_q.sub_sra;
  assign out_shamt   = out_q.shamt;
  assign out_a_sel   = out_q.a_sel;
  assign out_b_sel   = out_q.b_sel;
  assign out_imm     = out_q.imm;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rd      = out_q.rd;
  assign out_rd_we   = out_q.rd_we;
  assign out_pc      = out_q.pc;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Testbench for alu_decode_stage: a reference decoder feeds a scoreboard
// queue on every accepted input; every cycle the output is valid it is
// compared against the queue head, and popped when it transfers.
module tb_alu_decode_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_func;
  logic        out_sub_sra;
  logic [4:0]  out_shamt;
  logic [1:0]  out_a_sel;
  logic        out_b_sel;
  logic [31:0] out_imm;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [31:0] out_pc;
  logic        out_illegal;

  int checks    = 0;
  int failures  = 0;
  int out_xfers = 0;
  int cycle     = 0;
  dec_bundle_t sb[$];

  alu_decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_func    (out_func),
    .out_sub_sra (out_sub_sra),
    .out_shamt   (out_shamt),
    .out_a_sel   (out_a_sel),
    .out_b_sel   (out_b_sel),
    .out_imm     (out_imm),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .out_rd_we   (out_rd_we),
    .out_pc      (out_pc),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decoder, written from the ISA tables.
  function automatic dec_bundle_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
    dec_bundle_t d;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ok;
    d  = '0;
    f3 = i[14:12];
    f7 = i[31:25];
    ok = 1'b0;
    d.pc = pc;
    if (i[6:0] == 7'b0110011) begin
      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      case (f3)
        3'd0: d.func = 4'd0;  3'd1: d.func = 4'd5;
        3'd2: d.func = 4'd8;  3'd3: d.func = 4'd9;
        3'd4: d.func = 4'd1;  3'd5: d.func = 4'd6;
        3'd6: d.func = 4'd2;  default: d.func = 4'd3;
      endcase
      d.sub_sra = f7[5];
      d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.rd = i[11:7]; d.rd_we = 1'b1;
    end else if (i[6:0] == 7'b0010011) begin
      ok = (f3 == 3'd1) ? (f7 == 7'h00) :
           (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      case (f3)
        3'd0: d.func = 4'd0;  3'd1: d.func = 4'd4;
        3'd2: d.func = 4'd8;  3'd3: d.func = 4'd9;
        3'd4: d.func = 4'd1;  3'd5: d.func = 4'd7;
        3'd6: d.func = 4'd2;  default: d.func = 4'd3;
      endcase
      d.sub_sra = (f3 == 3'd5) && i[30];
      d.shamt   = (f3 == 3'd1 || f3 == 3'd5) ? i[24:20] : 5'd0;
      d.b_sel = 1'b1;
      d.imm   = {{20{i[31]}}, i[31:20]};
      d.rs1 = i[19:15]; d.rd = i[11:7]; d.rd_we = 1'b1;
    end else if (i[6:0] == 7'b0110111 || i[6:0] == 7'b0010111) begin
      ok = 1'b1;
      d.a_sel = (i[5]) ? 2'b10 : 2'b01;
      d.b_sel = 1'b1;
      d.imm   = {i[31:12], 12'h000};
      d.rd = i[11:7]; d.rd_we = 1'b1;
    end
    if (!ok) begin
      d = '0;
      d.pc = pc;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  function automatic dec_bundle_t cur_bundle();
    dec_bundle_t d;
    d.func = out_func;   d.sub_sra = out_sub_sra; d.shamt = out_shamt;
    d.a_sel = out_a_sel; d.b_sel = out_b_sel;     d.imm = out_imm;
    d.rs1 = out_rs1;     d.rs2 = out_rs2;         d.rd = out_rd;
    d.rd_we = out_rd_we; d.pc = out_pc;           d.illegal = out_illegal;
    return d;
  endfunction

  // Scoreboard monitor, sampled on the falling edge ahead of each transfer.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) check("unexpected_out", 1'b1, 1'b0);
        else                check("bundle", cur_bundle(), sb[0]);
      end
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready && sb.size() > 0) begin
          void'(sb.pop_front());
          out_xfers++;
        end
        if (in_valid && in_ready) sb.push_back(ref_decode(in_inst, in_pc));
      end
    end
  end

  // Present one instruction and hold it until accepted; returns 1 time
  // unit after the accepting edge with in_valid still high.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    int x0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_inst = '0; in_pc = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready",  in_ready, 1'b1);
    check("rst_func",      out_func, 4'h0);
    check("rst_imm",       out_imm, 32'h0);
    check("rst_pc",        out_pc, 32'h0);
    check("rst_illegal",   out_illegal, 1'b0);
    rst = 1'b0;
    out_ready = 1'b1;

    // sub x3,x1,x2: one-cycle latency
    send(32'h402081B3, 32'h0000_0000);
    check("lat_valid", out_valid, 1'b1);
    check("sub_func", out_func, 4'h0);
    check("sub_sra",  out_sub_sra, 1'b1);
    check("sub_bsel", out_b_sel, 1'b0);
    check("sub_regs", {out_rd, out_rs1, out_rs2}, {5'd3, 5'd1, 5'd2});

    send(32'h40735293, 32'h0000_0004);  // srai x5,x6,7
    check("srai_func",  out_func, 4'h7);
    check("srai_sra",   out_sub_sra, 1'b1);
    check("srai_shamt", out_shamt, 5'd7);
    check("srai_bsel",  out_b_sel, 1'b1);
    check("srai_we",    out_rd_we, 1'b1);
    send(32'hFFF00093, 32'h0000_0008);  // addi x1,x0,-1
    check("addi_sra", out_sub_sra, 1'b0);
    check("addi_imm", out_imm, 32'hFFFF_FFFF);
    send(32'h123453B7, 32'h0000_000C);  // lui x7,0x12345
    check("lui_asel", out_a_sel, 2'b10);
    check("lui_imm",  out_imm, 32'h1234_5000);
    send(32'h00001117, 32'h0000_0100);  // auipc x2,1
    check("auipc_asel", out_a_sel, 2'b01);
    check("auipc_pc",   out_pc, 32'h0000_0100);
    send(32'hFFFFFFFF, 32'h0000_0104);
    check("ill_flag", out_illegal, 1'b1);
    check("ill_we",   out_rd_we, 1'b0);
    check("ill_func", out_func, 4'h0);
    send(32'h02109093, 32'h0000_0108);  // slli with inst[25]=1
    check("slli_bad", out_illegal, 1'b1);
    send(32'h402091B3, 32'h0000_010C);  // sll with funct7=0100000
    check("sll_bad", out_illegal, 1'b1);
    send(32'h00000000, 32'h0000_0110);  // inst[1:0]=00
    check("low_bits_bad", out_illegal, 1'b1);
    send(32'h0020F1B3, 32'h0000_0114);  // and x3,x1,x2
    check("and_func", out_func, 4'h3);
    idle_cycles(2);

    // Backpressure: fill both entries, then release
    out_ready = 1'b0;
    send(32'h00100093, 32'h0000_0200);
    send(32'h00200113, 32'h0000_0204);
    check("full_in_ready",  in_ready, 1'b0);
    check("full_out_valid", out_valid, 1'b1);
    in_inst = 32'h00300193; in_pc = 32'h0000_0208;
    @(posedge clk);
    #1;
    check("still_full", in_ready, 1'b0);
    check("stall_head_rd", out_rd, 5'd1);
    out_ready = 1'b1;
    send(32'h00300193, 32'h0000_0208);
    send(32'h00400213, 32'h0000_020C);

    // Throughput: back-to-back sends take one cycle each
    c0 = cycle;
    for (int k = 0; k < 8; k++) send({12'(k + 16), 5'd0, 3'b000, 5'(k + 8), 7'b0010011}, 32'h300 + 32'(4 * k));
    check("throughput_cycles", cycle - c0, 8);
    idle_cycles(2);
    check("drained", out_valid, 1'b0);

    // Flush with both entries full and a new input offered
    out_ready = 1'b0;
    send(32'h00A00513, 32'h0000_0400);
    send(32'h00B00593, 32'h0000_0404);
    x0 = out_xfers;
    in_inst = 32'h00C00613; in_pc = 32'h0000_0408; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready",  in_ready, 1'b1);
    out_ready = 1'b1;
    idle_cycles(3);
    check("flush_no_out", out_xfers, x0);
    send(32'h00D00693, 32'h0000_0500);
    check("post_flush_rd", out_rd, 5'd13);
    idle_cycles(2);

    // Reset while both entries are held
    out_ready = 1'b0;
    send(32'h00E00713, 32'h0000_0600);
    send(32'h00F00793, 32'h0000_0604);
    x0 = out_xfers;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_ready", in_ready, 1'b1);
    check("mid_rst_imm",   out_imm, 32'h0);
    out_ready = 1'b1;
    idle_cycles(3);
    check("mid_rst_no_out", out_xfers, x0);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
